// File: rtl/soi_obs_pkg.sv
// soi_obs_pkg: shared types and default widths for the SOI change-capture block.
package soi_obs_pkg;
  localparam int SOI_W_DEF  = 1;
  localparam int TS_W_DEF   = 32;
  localparam int DEPTH_DEF  = 16;
  localparam int DROP_W_DEF = 16;
  typedef enum logic {IDLE, TRACK} cap_state_e;
  typedef struct packed {
    logic [TS_W_DEF-1:0]  ts;
    logic [SOI_W_DEF-1:0] value;
    logic                 lost;
  } soi_entry_t;
endpackage

// File: rtl/soi_fifo.sv
// soi_fifo: synchronous first-word-fall-through FIFO with wrap-bit pointers.
//   push_i/wdata_i  write side; a push is taken when not full or when a pop happens in the same cycle
//   pop_i/rdata_o   read side; rdata_o shows the head entry and reads 0 while empty
//   full_o/empty_o/count_o  occupancy status
module soi_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [W-1:0]             wdata_i,
  input  logic                     pop_i,
  output logic [W-1:0]             rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         do_push, do_pop;
  assign empty_o = wr_q == rd_q;
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign wr_d    = do_push ? wr_q + (AW+1)'(1) : wr_q;
  assign rd_d    = do_pop ? rd_q + (AW+1)'(1) : rd_q;
  assign count_o = wr_q - rd_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_q[AW-1:0]];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
  end
endmodule

// File: rtl/soi_capture.sv
// soi_capture: records every change of the signal of interest as a timestamped FIFO entry.
//   enable/soi      capture control and observed signal
//   rd_*            FWFT read port (valid/ready) carrying ts, value and lost flag
//   count/drop_cnt  FIFO occupancy and saturating count of dropped entries
module soi_capture
  import soi_obs_pkg::*;
#(
  parameter int SOI_W  = SOI_W_DEF,
  parameter int TS_W   = TS_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DROP_W = DROP_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [SOI_W-1:0]       soi,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [TS_W-1:0]        rd_ts,
  output logic [SOI_W-1:0]       rd_value,
  output logic                   rd_lost,
  output logic [$clog2(DEPTH):0] count,
  output logic [DROP_W-1:0]      drop_cnt
);
  typedef struct packed {
    logic [TS_W-1:0]  ts;
    logic [SOI_W-1:0] value;
    logic             lost;
  } entry_t;
  cap_state_e        state_q, state_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [SOI_W-1:0]  last_q;
  logic              lost_q, lost_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              due, full, empty, pop, push_ok, drop;
  entry_t            wr_e, rd_e;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ts_q    <= '0;
      last_q  <= '0;
      lost_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      last_q  <= soi;
      lost_q  <= lost_d;
      drop_q  <= drop_d;
    end
  end
  always_comb state_d = enable ? TRACK : IDLE;
  // Entering TRACK always records a baseline; in TRACK only changes are recorded.
  always_comb due = enable && (state_q == IDLE || soi != last_q);
  assign pop     = rd_valid && rd_ready;
  assign push_ok = due && (!full || pop);
  assign drop    = due && !push_ok;
  assign ts_d    = ts_q + TS_W'(1);
  assign lost_d  = push_ok ? 1'b0 : drop ? 1'b1 : lost_q;
  assign drop_d  = (drop && !(&drop_q)) ? drop_q + DROP_W'(1) : drop_q;
  assign wr_e    = '{ts: ts_q, value: soi, lost: lost_q};
  soi_fifo #(.DEPTH(DEPTH), .W($bits(entry_t))) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_ok),
    .wdata_i (wr_e),
    .pop_i   (pop),
    .rdata_o (rd_e),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  assign rd_valid = !empty;
  assign rd_ts    = rd_e.ts;
  assign rd_value = rd_e.value;
  assign rd_lost  = rd_e.lost;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_soi_capture.sv
// tb_soi_capture: directed table and sequence checks for soi_capture.
module tb_soi_capture;
  logic        clk = 1'b0, rst = 1'b1, enable = 1'b0, rd_ready = 1'b0;
  logic [0:0]  soi = 1'b1;
  logic        rd_valid, rd_lost;
  logic [31:0] rd_ts;
  logic [0:0]  rd_value;
  logic [4:0]  count;
  logic [15:0] drop_cnt;
  int total = 0, fails = 0, cyc = 0;
  typedef struct {int rst; int en; int soi; int rdy; int v; int ts; int val; int lost; int cnt; int drop;} vec_t;
  typedef struct {int ts; int val; int lost;} ent_t;
  vec_t tbl [17];
  ent_t exp_q [$];
  logic s;
  soi_capture dut (
    .clk(clk), .rst(rst), .enable(enable), .soi(soi),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_ts(rd_ts),
    .rd_value(rd_value), .rd_lost(rd_lost), .count(count), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
  task automatic step(input logic r, input logic e, input logic sv, input logic y);
    rst = r; enable = e; soi = sv; rd_ready = y;
    @(posedge clk);
    #1;
    cyc = r ? 0 : cyc + 1;
  endtask
  task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %0d expected %0d", n, got, exp);
    end
  endtask
  task automatic chk_head(input string n);
    if (exp_q.size() == 0) begin
      chk({n, ".noexp"}, 64'(rd_valid), 64'd0);
      return;
    end
    chk({n, ".valid"}, 64'(rd_valid), 64'd1);
    chk({n, ".ts"}, 64'(rd_ts), 64'(exp_q[0].ts));
    chk({n, ".value"}, 64'(rd_value), 64'(exp_q[0].val));
    chk({n, ".lost"}, 64'(rd_lost), 64'(exp_q[0].lost));
  endtask
  task automatic pop_step(input string n, input logic sv);
    chk_head(n);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    step(1'b0, 1'b1, sv, 1'b1);
  endtask
  task automatic push_exp(input logic sv, input int lost);
    exp_q.push_back('{ts: cyc, val: int'(sv), lost: lost});
  endtask
  initial begin
    tbl = '{
      '{1,0,1,0, 0, 0,0,0, 0,0},
      '{0,0,1,0, 0, 0,0,0, 0,0},
      '{0,0,1,0, 0, 0,0,0, 0,0},
      '{0,0,1,0, 0, 0,0,0, 0,0},
      '{0,1,1,0, 1, 3,1,0, 1,0},
      '{0,1,1,1, 0, 0,0,0, 0,0},
      '{0,1,1,1, 0, 0,0,0, 0,0},
      '{0,1,1,1, 0, 0,0,0, 0,0},
      '{0,1,1,1, 0, 0,0,0, 0,0},
      '{0,1,1,1, 0, 0,0,0, 0,0},
      '{0,1,1,1, 0, 0,0,0, 0,0},
      '{0,1,0,1, 1,10,0,0, 1,0},
      '{0,1,1,1, 1,11,1,0, 1,0},
      '{0,1,0,1, 1,12,0,0, 1,0},
      '{0,1,1,1, 1,13,1,0, 1,0},
      '{0,1,0,1, 1,14,0,0, 1,0},
      '{0,1,0,1, 0, 0,0,0, 0,0}
    };
    foreach (tbl[i]) begin
      step(tbl[i].rst[0], tbl[i].en[0], tbl[i].soi[0], tbl[i].rdy[0]);
      chk($sformatf("row%0d.valid", i), 64'(rd_valid), 64'(tbl[i].v));
      chk($sformatf("row%0d.ts", i), 64'(rd_ts), 64'(tbl[i].ts));
      chk($sformatf("row%0d.value", i), 64'(rd_value), 64'(tbl[i].val));
      chk($sformatf("row%0d.lost", i), 64'(rd_lost), 64'(tbl[i].lost));
      chk($sformatf("row%0d.count", i), 64'(count), 64'(tbl[i].cnt));
      chk($sformatf("row%0d.drop", i), 64'(drop_cnt), 64'(tbl[i].drop));
    end
    s = 1'b0;
    for (int k = 0; k < 20; k++) begin
      s = ~s;
      if (k < 16) push_exp(s, 0);
      step(1'b0, 1'b1, s, 1'b0);
    end
    chk("ovf.count", 64'(count), 64'd16);
    chk("ovf.drop", 64'(drop_cnt), 64'd4);
    for (int k = 0; k < 16; k++) pop_step($sformatf("ovf.drain%0d", k), s);
    chk("ovf.empty", 64'(rd_valid), 64'd0);
    chk("ovf.count0", 64'(count), 64'd0);
    s = ~s;
    push_exp(s, 1);
    step(1'b0, 1'b1, s, 1'b0);
    s = ~s;
    push_exp(s, 0);
    pop_step("ovf.lost1", s);
    pop_step("ovf.lost0", s);
    chk("ovf.count_end", 64'(count), 64'd0);
    for (int k = 0; k < 16; k++) begin
      s = ~s;
      push_exp(s, 0);
      step(1'b0, 1'b1, s, 1'b0);
    end
    chk("fullpop.pre_count", 64'(count), 64'd16);
    s = ~s;
    push_exp(s, 0);
    pop_step("fullpop.head", s);
    chk("fullpop.count", 64'(count), 64'd16);
    chk("fullpop.drop", 64'(drop_cnt), 64'd4);
    for (int k = 0; k < 16; k++) pop_step($sformatf("fullpop.drain%0d", k), s);
    chk("fullpop.count0", 64'(count), 64'd0);
    for (int k = 0; k < 5; k++) begin
      s = ~s;
      step(1'b0, 1'b0, s, 1'b0);
    end
    chk("dis.count", 64'(count), 64'd0);
    chk("dis.valid", 64'(rd_valid), 64'd0);
    push_exp(s, 0);
    step(1'b0, 1'b1, s, 1'b0);
    step(1'b0, 1'b1, s, 1'b0);
    chk("reen.count", 64'(count), 64'd1);
    pop_step("reen.base", s);
    chk("reen.count0", 64'(count), 64'd0);
    for (int k = 0; k < 7; k++) begin
      s = ~s;
      push_exp(s, 0);
      step(1'b0, 1'b1, s, 1'b0);
    end
    chk("rstmid.pre_count", 64'(count), 64'd7);
    step(1'b1, 1'b0, s, 1'b0);
    exp_q.delete();
    chk("rstmid.valid", 64'(rd_valid), 64'd0);
    chk("rstmid.count", 64'(count), 64'd0);
    chk("rstmid.drop", 64'(drop_cnt), 64'd0);
    chk("rstmid.ts", 64'(rd_ts), 64'd0);
    step(1'b0, 1'b0, s, 1'b0);
    step(1'b0, 1'b0, s, 1'b0);
    push_exp(s, 0);
    step(1'b0, 1'b1, s, 1'b0);
    chk_head("rstmid.ts_restart");
    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/soi_capture.md
# soi_capture

Change-capture stage that sits directly downstream of the observed design under test and consumes its signal of interest (SOI), such as the toggling `testval` bit. Every change of the SOI is recorded as a timestamped entry in an on-chip FIFO. The DPI read-out shim drains entries through a valid/ready port, so software sees an ordered, loss-flagged history instead of polling a single current value.

## Interface
- `SOI_W`, 1, width of the observed signal
- `TS_W`, 32, timestamp counter width
- `DEPTH`, 16, FIFO entries; power of two, ≥ 2
- `DROP_W`, 16, width of drop counter

- `clk`  in  1  single clock domain for the block
- `rst`  in  1  reset: synchronous, active-high
- `enable`  in  1  capture enable
- `soi`  in  SOI_W  signal of interest, synchronous to `clk`
- `rd_valid`  out  1  head entry available
- `rd_ready`  in  1  consumer accepts head entry
- `rd_ts`  out  TS_W  head entry timestamp
- `rd_value`  out  SOI_W  head entry SOI value
- `rd_lost`  out  1  one or more entries were dropped immediately before this one
- `count`  out  $clog2(DEPTH)+1  current FIFO occupancy
- `drop_cnt`  out  DROP_W  total dropped entries, saturating

## Operation
- `ts_cnt`: free-running counter.
  - 0 after reset; +1 every cycle; wraps modulo 2^TS_W.
- FSM with two states:
  - IDLE: no captures.
  - TRACK: comparing `soi` against `last_val` each cycle.
  - IDLE→TRACK on a cycle with `enable`=1. That cycle unconditionally records a baseline entry holding the current `soi`.
  - TRACK→IDLE on a cycle with `enable`=0. No entry is recorded in that cycle.
- In TRACK, an entry is recorded when `soi` != `last_val`.
- `last_val` loads `soi` every cycle in every state, even when the entry is dropped.
- Entry contents: {ts = `ts_cnt` in the sampling cycle, value = `soi`, lost = `lost_pend`}.
- FIFO full and an entry is due:
  - The entry is dropped.
  - `drop_cnt` increments, saturating at all-ones.
  - `lost_pend` is set.
- On a successful write, `lost_pend` clears.
- Pop occurs when `rd_valid` && `rd_ready`.
- Full with a simultaneous pop: the push is accepted, `count` stays DEPTH, and there is no drop.
- Empty with a simultaneous push: the new entry is not visible until the next cycle; no bypass.
- Dropping an entry never affects stored entries or the read port.

## Timing
- Reset values:
  - FSM = IDLE
  - `ts_cnt` = 0, `last_val` = 0, `lost_pend` = 0
  - `rd_valid` = 0, `rd_ts` = 0, `rd_value` = 0, `rd_lost` = 0
  - `count` = 0, `drop_cnt` = 0
- Reset mid-operation flushes the FIFO. All entries are discarded; nothing is drained.
- Capture latency: an entry sampled in cycle k is visible as `rd_valid`=1 in cycle k+1 if the FIFO was empty.
- Read port is first-word-fall-through:
  - `rd_ts`, `rd_value` and `rd_lost` are valid whenever `rd_valid`=1 and are held stable until the pop.
  - When `rd_valid`=0, they read as 0.
- Handshake rules:
  - `rd_valid` never deasserts without a pop, except on reset.
  - `rd_ready` may be high with `rd_valid` low; this has no effect.
- `count` is updated at the edge following the push/pop cycle. Throughput is one push and one pop per cycle.

## Structure
- Package `soi_obs_pkg` holds:
  - `soi_entry_t` parameterised struct typedef: ts, value, lost.
  - `cap_state_e` enum: IDLE, TRACK.
  - Default-width localparams.
- Sub-module `soi_fifo`: synchronous FWFT FIFO.
  - Parameters: DEPTH and entry width.
  - Pointers carry an extra wrap bit for the full/empty distinction.
  - Outputs: full, empty, count.
- `soi_capture` contains the FSM, `ts_cnt`, change detect, drop logic, and the `soi_fifo` instance.

## Test plan
- **Baseline:** reset, `soi`=1, assert `enable` in cycle 3 → one entry {ts=3, value=1, lost=0}; `rd_valid` high in cycle 4.
- **Toggle capture:** DEPTH=16, `soi` toggles every cycle from cycle 10 to cycle 14, `rd_ready`=1 throughout → entries with ts 10..14 and alternating values, in order, `drop_cnt`=0.
- **Overflow:** `rd_ready`=0, 20 changes → `count`=16, `drop_cnt`=4. Then drain → first 16 entries intact. The next entry recorded afterwards has lost=1; the one after that has lost=0.
- **Full with simultaneous pop:** FIFO full, push and pop in the same cycle → `count` stays 16, `drop_cnt` unchanged, order preserved.
- **Disable/enable:** `enable` low for 5 cycles while `soi` changes → no entries. Re-enable → exactly one baseline entry with the current value.
- **Reset mid-operation:** 7 entries queued, `rst` asserted for 1 cycle → `rd_valid`=0, `count`=0, `drop_cnt`=0, `ts_cnt` restarts from 0.
